ula_pipe: RTL and testbench

ULA_PIPE -- requirements
Module: ula_pipe

---
 rtl/ula_pipe.sv | 119 +++++++++++
 tb/tb_ula_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ula_pipe
// Description : Registered 32-bit logic/arithmetic unit with a small FIFO
//               result buffer and valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module ula_pipe #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  f,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] y,
    output logic        zero,
    output logic        err,
    output logic [15:0] op_count
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_FULL     = c_CW'(DEPTH);
    localparam logic [c_AW-1:0] c_LAST_PTR = c_AW'(DEPTH - 1);

    localparam logic [2:0] c_F_AND  = 3'b000;
    localparam logic [2:0] c_F_OR   = 3'b001;
    localparam logic [2:0] c_F_ADD  = 3'b010;
    localparam logic [2:0] c_F_ILL  = 3'b011;
    localparam logic [2:0] c_F_ANDN = 3'b100;
    localparam logic [2:0] c_F_ORN  = 3'b101;
    localparam logic [2:0] c_F_SUB  = 3'b110;
    localparam logic [2:0] c_F_SLT  = 3'b111;

    logic [c_CW-1:0] r_count;
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [15:0]     r_op_count;
    logic            r_live;

    // Entry layout: {err, zero, y}
    logic [33:0]     r_mem [DEPTH];

    logic [31:0]     w_res;
    logic [31:0]     w_diff;
    logic            w_err;
    logic            w_zero;
    logic            w_push;
    logic            w_pop;
    logic [33:0]     w_head;

    always_comb begin
        w_diff = a - b;
        w_res  = 32'd0;
        w_err  = 1'b0;
        case (f)
            c_F_AND:  w_res = a & b;
            c_F_OR:   w_res = a | b;
            c_F_ADD:  w_res = a + b;
            c_F_ILL:  w_err = 1'b1;
            c_F_ANDN: w_res = a & ~b;
            c_F_ORN:  w_res = a | ~b;
            c_F_SUB:  w_res = w_diff;
            c_F_SLT:  w_res = {31'd0, w_diff[31]};
            default:  w_err = 1'b1;
        endcase
        w_zero = (w_res == 32'd0);
    end

    // r_live keeps req_ready low until the first clock edge out of reset.
    assign req_ready = r_live && (r_count < c_FULL);
    assign rsp_valid = (r_count != '0);
    assign w_push    = req_valid && req_ready;
    assign w_pop     = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_op_count <= 16'd0;
            r_live     <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_push) begin
                r_wptr <= (r_wptr == c_LAST_PTR) ? '0 : r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rptr     <= (r_rptr == c_LAST_PTR) ? '0 : r_rptr + c_AW'(1);
                r_op_count <= r_op_count + 16'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count decide what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_err, w_zero, w_res};
        end
    end

    assign w_head   = r_mem[r_rptr];
    assign y        = rsp_valid ? w_head[31:0] : 32'd0;
    assign zero     = rsp_valid ? w_head[32]   : 1'b1;
    assign err      = rsp_valid ? w_head[33]   : 1'b0;
    assign op_count = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_ula_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ula_pipe
// Description : Self-checking bench for ula_pipe against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ula_pipe;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] y;
    logic        zero;
    logic        err;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] y;
        logic        z;
        logic        e;
    } ent_t;

    ent_t q[$];
    int   exp_cnt = 0;
    bit   live    = 0;

    ula_pipe #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .f         (f),
        .a         (a),
        .b         (b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .y         (y),
        .zero      (zero),
        .err       (err),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    function automatic ent_t ref_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] w);
        ent_t        r;
        logic [63:0] wide;
        logic [31:0] d;
        r.e = 1'b0;
        wide = 64'(x) + 64'(w);
        d = 32'((64'(x) + 64'h1_0000_0000 - 64'(w)) & 64'hFFFF_FFFF);
        case (op)
            3'd0:    r.y = x & w;
            3'd1:    r.y = x | w;
            3'd2:    r.y = wide[31:0];
            3'd4:    r.y = x & ~w;
            3'd5:    r.y = x | ~w;
            3'd6:    r.y = d;
            3'd7:    r.y = (d >= 32'h8000_0000) ? 32'd1 : 32'd0;
            default: begin r.y = 32'd0; r.e = 1'b1; end
        endcase
        r.z = (r.y == 32'd0);
        return r;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Drive one clock: inputs applied after a falling edge, model advanced at the rising edge.
    task automatic clk_cycle(input logic v, input logic [2:0] op, input logic [31:0] x,
                             input logic [31:0] w, input logic rr);
        bit do_push;
        bit do_pop;
        req_valid = v;
        f         = op;
        a         = x;
        b         = w;
        rsp_ready = rr;
        do_push = reset_n && v && live && (q.size() < DEPTH);
        do_pop  = reset_n && rr && (q.size() > 0);
        @(posedge clk);
        if (reset_n) begin
            if (do_pop) begin
                q.delete(0);
                exp_cnt++;
            end
            if (do_push) q.push_back(ref_op(op, x, w));
            live = 1;
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        f = 3'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH + 2 && q.size() > 0; i++) clk_cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clk_cycle(1, 3'd2, 32'd1, 32'd2, 1);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        checks++; if (y !== 32'd0) begin errors++; $display("FAIL reset_y got=%h exp=0", y); end
        checks++; if (zero !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL reset_flags got zero=%b err=%b exp zero=1 err=0", zero, err); end
        checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count got=%h exp=0", op_count); end
        reset_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_release_ready_early got=%b exp=0", req_ready); end
        clk_cycle(0, 0, 0, 0, 0);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0 || y !== 32'd0 || zero !== 1'b1) begin
            errors++; $display("FAIL post_reset_idle got valid=%b y=%h zero=%b exp valid=0 y=0 zero=1", rsp_valid, y, zero);
        end
    endtask

    task automatic test_add_basic();
        clk_cycle(1, 3'b010, 32'h5, 32'h7, 1);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_rsp_valid got=%b exp=1", rsp_valid); end
        checks++; if (y !== 32'h0000_000C || zero !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL add_result got y=%h zero=%b err=%b exp y=0000000c zero=0 err=0", y, zero, err);
        end
        checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL add_count_before got=%h exp=0", op_count); end
        clk_cycle(0, 0, 0, 0, 1);
        checks++; if (op_count !== 16'd1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL add_count_after got count=%h valid=%b exp count=1 valid=0", op_count, rsp_valid);
        end
    endtask

    task automatic test_directed_ops();
        logic [2:0]  t_f [4] = '{3'b110, 3'b111, 3'b011, 3'b101};
        logic [31:0] t_a [4] = '{32'h3, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0};
        logic [31:0] t_b [4] = '{32'h3, 32'h1, 32'h9, 32'hFFFF_FFFF};
        logic [31:0] t_y [4] = '{32'h0, 32'h1, 32'h0, 32'h0};
        logic        t_z [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic        t_e [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            clk_cycle(1, t_f[i], t_a[i], t_b[i], 0);
            checks++; if (y !== t_y[i] || zero !== t_z[i] || err !== t_e[i]) begin
                errors++; $display("FAIL directed_op%0d got y=%h zero=%b err=%b exp y=%h zero=%b err=%b",
                                   i, y, zero, err, t_y[i], t_z[i], t_e[i]);
            end
            clk_cycle(0, 0, 0, 0, 1);
            checks++; if (op_count !== exp_cnt[15:0]) begin
                errors++; $display("FAIL directed_count%0d got=%h exp=%h", i, op_count, exp_cnt[15:0]);
            end
        end
    endtask

    task automatic test_random_ops();
        for (int i = 0; i < 300; i++) begin
            clk_cycle(1'($urandom_range(0, 3) != 0), 3'($urandom), rand_operand(), rand_operand(),
                      1'($urandom_range(0, 2) != 0));
            checks++; if (rsp_valid !== (q.size() > 0)) begin
                errors++; $display("FAIL rand_valid cycle %0d got=%b exp=%b", i, rsp_valid, q.size() > 0);
            end
            checks++; if (req_ready !== (live && q.size() < DEPTH)) begin
                errors++; $display("FAIL rand_ready cycle %0d got=%b exp=%b", i, req_ready, q.size() < DEPTH);
            end
            checks++; if (op_count !== exp_cnt[15:0]) begin
                errors++; $display("FAIL rand_count cycle %0d got=%h exp=%h", i, op_count, exp_cnt[15:0]);
            end
            if (q.size() > 0) begin
                checks++; if (y !== q[0].y || zero !== q[0].z || err !== q[0].e) begin
                    errors++; $display("FAIL rand_head cycle %0d got y=%h zero=%b err=%b exp y=%h zero=%b err=%b",
                                       i, y, zero, err, q[0].y, q[0].z, q[0].e);
                end
            end
        end
        drain();
    endtask

    task automatic test_full_backpressure();
        logic [31:0] xa [3];
        logic [31:0] xb [3];
        logic [2:0]  xf [3];
        ent_t        e1, e2;
        int          c0;
        drain();
        for (int i = 0; i < 3; i++) begin
            xa[i] = rand_operand(); xb[i] = rand_operand(); xf[i] = 3'($urandom);
        end
        e1 = ref_op(xf[0], xa[0], xb[0]);
        e2 = ref_op(xf[1], xa[1], xb[1]);
        c0 = exp_cnt;
        clk_cycle(1, xf[0], xa[0], xb[0], 0);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_ready_one got=%b exp=1", req_ready); end
        clk_cycle(1, xf[1], xa[1], xb[1], 0);
        checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
            errors++; $display("FAIL full_flags got ready=%b valid=%b exp ready=0 valid=1", req_ready, rsp_valid);
        end
        clk_cycle(1, xf[2], xa[2], xb[2], 0);
        checks++; if (y !== e1.y || zero !== e1.z || err !== e1.e || req_ready !== 1'b0) begin
            errors++; $display("FAIL full_hold got y=%h ready=%b exp y=%h ready=0", y, req_ready, e1.y);
        end
        clk_cycle(0, 0, 0, 0, 1);
        checks++; if (y !== e2.y || zero !== e2.z || err !== e2.e || rsp_valid !== 1'b1) begin
            errors++; $display("FAIL full_second got y=%h valid=%b exp y=%h valid=1", y, rsp_valid, e2.y);
        end
        clk_cycle(0, 0, 0, 0, 1);
        checks++; if (rsp_valid !== 1'b0 || op_count !== 16'(c0 + 2)) begin
            errors++; $display("FAIL full_drain got valid=%b count=%h exp valid=0 count=%h", rsp_valid, op_count, 16'(c0 + 2));
        end
    endtask

    task automatic test_push_pop_same();
        int c0;
        drain();
        clk_cycle(1, 3'($urandom), rand_operand(), rand_operand(), 0);
        c0 = exp_cnt;
        for (int i = 0; i < 10; i++) begin
            clk_cycle(1, 3'($urandom), rand_operand(), rand_operand(), 1);
            checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b1) begin
                errors++; $display("FAIL same_occupancy cycle %0d got valid=%b ready=%b exp 1 1", i, rsp_valid, req_ready);
            end
            checks++; if (y !== q[0].y || zero !== q[0].z || err !== q[0].e) begin
                errors++; $display("FAIL same_head cycle %0d got y=%h exp y=%h", i, y, q[0].y);
            end
        end
        checks++; if (op_count !== 16'(c0 + 10)) begin
            errors++; $display("FAIL same_count got=%h exp=%h", op_count, 16'(c0 + 10));
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic [31:0] x, w;
        drain();
        clk_cycle(1, 3'd0, rand_operand(), rand_operand(), 0);
        clk_cycle(1, 3'd1, rand_operand(), rand_operand(), 0);
        checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_full got ready=%b valid=%b exp ready=0 valid=1", req_ready, rsp_valid);
        end
        #2 reset_n = 1'b0;
        q.delete(); exp_cnt = 0; live = 0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || op_count !== 16'd0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_immediate got valid=%b count=%h ready=%b exp 0 0 0", rsp_valid, op_count, req_ready);
        end
        checks++; if (y !== 32'd0 || zero !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got y=%h zero=%b err=%b exp y=0 zero=1 err=0", y, zero, err);
        end
        @(negedge clk);
        clk_cycle(1, 3'd2, 32'hDEAD_0000, 32'h0000_BEEF, 1);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_inflight got valid=%b exp=0", rsp_valid); end
        reset_n = 1'b1;
        clk_cycle(0, 0, 0, 0, 0);
        x = $urandom; w = $urandom;
        clk_cycle(1, 3'd2, x, w, 0);
        checks++; if (rsp_valid !== 1'b1 || y !== x + w) begin
            errors++; $display("FAIL midrst_first got valid=%b y=%h exp valid=1 y=%h", rsp_valid, y, x + w);
        end
        clk_cycle(0, 0, 0, 0, 1);
        checks++; if (rsp_valid !== 1'b0 || op_count !== 16'd1) begin
            errors++; $display("FAIL midrst_no_stale got valid=%b count=%h exp valid=0 count=1", rsp_valid, op_count);
        end
    endtask

    task automatic test_wrap();
        reset_n = 1'b0;
        q.delete(); exp_cnt = 0; live = 0;
        clk_cycle(0, 0, 0, 0, 0);
        reset_n = 1'b1;
        clk_cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 65537; i++) begin
            clk_cycle(1, 3'd2, $urandom, $urandom, 1);
            checks++; if (rsp_valid !== 1'b1 || y !== q[0].y) begin
                errors++; $display("FAIL wrap_stream cycle %0d got valid=%b y=%h exp valid=1 y=%h", i, rsp_valid, y, q[0].y);
            end
        end
        clk_cycle(0, 0, 0, 0, 1);
        checks++; if (op_count !== 16'h0001 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_count got count=%h valid=%b exp count=0001 valid=0", op_count, rsp_valid);
        end
    endtask

    initial begin
        clk       = 1'b0;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        f         = 3'd0;
        a         = 32'd0;
        b         = 32'd0;
        @(negedge clk);
        test_reset();
        test_add_basic();
        test_directed_ops();
        test_random_ops();
        test_full_backpressure();
        test_push_pop_same();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
